// File: rtl/exec_issue.sv
// Issue/collect sequencer in front of the execute stage: accepts one op,
// holds it on the execute inputs until done or timed out, then offers the result.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream op handshake
//   in_opcode, in_mask       op code and lane enables
//   in_dataA/in_dataB/in_imm operands
//   enable_alu, opcode       execute control (enable only while waiting)
//   dataA, dataB, data_imm   execute operands (registered copies)
//   ex_valid/ex_zero/ex_data execute completion, flag and result
//   out_valid/out_ready      downstream result handshake
//   out_data/out_zero        captured result and zero flag
//   out_timeout              result came from a watchdog abort
//   busy                     an op is in flight or waiting to be taken
module exec_issue #(
    parameter int N       = 32,
    parameter int Q       = 16,
    parameter int ALU_NUM = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [3:0]                      in_opcode,
    input  logic [ALU_NUM-1:0]              in_mask,
    input  logic signed [ALU_NUM*N-1:0]     in_dataA,
    input  logic signed [ALU_NUM*N-1:0]     in_dataB,
    input  logic [ALU_NUM-1:0]              in_imm,
    output logic [ALU_NUM-1:0]              enable_alu,
    output logic [3:0]                      opcode,
    output logic signed [ALU_NUM*N-1:0]     dataA,
    output logic signed [ALU_NUM*N-1:0]     dataB,
    output logic [ALU_NUM-1:0]              data_imm,
    input  logic                            ex_valid,
    input  logic                            ex_zero,
    input  logic [ALU_NUM*N-1:0]            ex_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ALU_NUM*N-1:0]            out_data,
    output logic                            out_zero,
    output logic                            out_timeout,
    output logic                            busy
);

    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      OP_SHIFT = 4'b0100;

    // Q only documents the lane format shared with the ALUs; the
    // sequencer never interprets the data, so it just names the
    // degenerate case of having no integer bits.
    if (Q >= N) begin : g_q_no_int_bits
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [WD_W-1:0]         wdog_q;
    logic [3:0]              opcode_q;
    logic [ALU_NUM-1:0]      mask_q;
    logic [ALU_NUM*N-1:0]    dataa_q;
    logic [ALU_NUM*N-1:0]    datab_q;
    logic [ALU_NUM-1:0]      imm_q;
    logic [ALU_NUM*N-1:0]    res_data_q;
    logic                    res_zero_q;
    logic                    res_to_q;

    logic accept;
    logic bypass;
    logic wd_expire;

    assign accept    = (state_q == IDLE) && in_valid;
    // An empty mask has nothing to compute, except for shift which
    // execute still has to see.
    assign bypass    = (in_mask == '0) && (in_opcode != OP_SHIFT);
    // The counter started at 0 in the first WAIT cycle, so this is the
    // TIMEOUT-th cycle spent waiting.
    assign wd_expire = (wdog_q == WD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = bypass ? HOLD : WAIT;
                end
            end
            WAIT: begin
                if (ex_valid || wd_expire) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        enable_alu = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            WAIT: enable_alu = mask_q;
            HOLD: out_valid  = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Operand, watchdog and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q     <= '0;
            opcode_q   <= '0;
            mask_q     <= '0;
            dataa_q    <= '0;
            datab_q    <= '0;
            imm_q      <= '0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            res_to_q   <= 1'b0;
        end else begin
            if (accept) begin
                opcode_q <= in_opcode;
                mask_q   <= in_mask;
                dataa_q  <= in_dataA;
                datab_q  <= in_dataB;
                imm_q    <= in_imm;
                wdog_q   <= '0;
                if (bypass) begin
                    res_data_q <= '0;
                    res_zero_q <= 1'b1;
                    res_to_q   <= 1'b0;
                end
            end
            if (state_q == WAIT) begin
                wdog_q <= wdog_q + 1'b1;
                if (ex_valid) begin
                    res_data_q <= ex_data;
                    res_zero_q <= ex_zero;
                    res_to_q   <= 1'b0;
                end else if (wd_expire) begin
                    res_data_q <= '0;
                    res_zero_q <= 1'b0;
                    res_to_q   <= 1'b1;
                end
            end
        end
    end

    assign opcode      = opcode_q;
    assign dataA       = dataa_q;
    assign dataB       = datab_q;
    assign data_imm    = imm_q;
    assign out_data    = res_data_q;
    assign out_zero    = res_zero_q;
    assign out_timeout = res_to_q;

endmodule

// File: tb/tb_exec_issue.sv
// Randomized bench for exec_issue with a transaction-level model of
// the issue/collect timing and result selection.
module tb_exec_issue;

    localparam int N  = 32;
    localparam int AN = 24;
    localparam int TO = 255;
    localparam int W  = AN * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [AN-1:0] in_mask;
    logic [W-1:0]  in_dataA;
    logic [W-1:0]  in_dataB;
    logic [AN-1:0] in_imm;
    logic [AN-1:0] enable_alu;
    logic [3:0]    opcode;
    logic [W-1:0]  dataA;
    logic [W-1:0]  dataB;
    logic [AN-1:0] data_imm;
    logic          ex_valid;
    logic          ex_zero;
    logic [W-1:0]  ex_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          out_timeout;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    exec_issue #(.N(N), .Q(16), .ALU_NUM(AN), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_mask    (in_mask),
        .in_dataA   (in_dataA),
        .in_dataB   (in_dataB),
        .in_imm     (in_imm),
        .enable_alu (enable_alu),
        .opcode     (opcode),
        .dataA      (dataA),
        .dataB      (dataB),
        .data_imm   (data_imm),
        .ex_valid   (ex_valid),
        .ex_zero    (ex_zero),
        .ex_data    (ex_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_timeout(out_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        for (int i = 0; i < AN; i++) v[i*N +: N] = $urandom;
        return v;
    endfunction

    task automatic junk_upstream();
        in_valid  = 1'($urandom);
        in_opcode = 4'($urandom);
        in_mask   = AN'($urandom);
        in_dataA  = rnd_vec();
        in_dataB  = rnd_vec();
        in_imm    = AN'($urandom);
    endtask

    // One op: k = cycle (1-based, after accept) in which the stub raises
    // ex_valid; k > TO means never. hold = extra cycles out_ready stays 0.
    task automatic run_op(input logic [3:0] op, input logic [AN-1:0] m,
                          input int k, input int hold,
                          input logic [W-1:0] rd, input logic rz);
        logic [W-1:0]  a, b, exp_d;
        logic [AN-1:0] im;
        logic          bypass, exp_z, exp_to;
        int            nwait;
        a  = rnd_vec();
        b  = rnd_vec();
        im = AN'($urandom);
        in_valid  = 1'b1;
        in_opcode = op;
        in_mask   = m;
        in_dataA  = a;
        in_dataB  = b;
        in_imm    = im;
        ex_valid  = 1'b0;
        out_ready = 1'b0;
        chk("in_ready_idle", in_ready, 1);
        chk("enable_idle", enable_alu, 0);
        tick();
        junk_upstream();
        bypass = (m == 0) && (op != 4'b0100);
        if (bypass) begin
            nwait = 0;
            exp_d = '0; exp_z = 1'b1; exp_to = 1'b0;
        end else if (k <= TO) begin
            nwait = k;
            exp_d = rd; exp_z = rz; exp_to = 1'b0;
        end else begin
            nwait = TO;
            exp_d = '0; exp_z = 1'b0; exp_to = 1'b1;
        end
        for (int w = 1; w <= nwait; w++) begin
            chk("enable_wait", enable_alu, m);
            chk("out_valid_wait", out_valid, 0);
            chk("in_ready_wait", in_ready, 0);
            chk("busy_wait", busy, 1);
            chk("opcode_wait", opcode, op);
            chk("dataA_wait", dataA, a);
            chk("dataB_wait", dataB, b);
            chk("imm_wait", data_imm, im);
            ex_valid = (w == k);
            ex_data  = (w == k) ? rd : rnd_vec();
            ex_zero  = (w == k) ? rz : 1'($urandom);
            junk_upstream();
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            chk("out_valid_hold", out_valid, 1);
            chk("enable_hold", enable_alu, 0);
            chk("in_ready_hold", in_ready, 0);
            chk("busy_hold", busy, 1);
            chk("out_data", out_data, exp_d);
            chk("out_zero", out_zero, exp_z);
            chk("out_timeout", out_timeout, exp_to);
            chk("dataA_hold", dataA, a);
            out_ready = (h == hold);
            ex_valid  = 1'($urandom);
            ex_zero   = 1'($urandom);
            ex_data   = rnd_vec();
            junk_upstream();
            tick();
        end
        out_ready = 1'b0;
        ex_valid  = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        logic [W-1:0]  rd;
        logic [AN-1:0] m;
        int            k;
        rst = 1'b1;
        in_valid = 1'b0; in_opcode = '0; in_mask = '0;
        in_dataA = '0; in_dataB = '0; in_imm = '0;
        ex_valid = 1'b0; ex_zero = 1'b0; ex_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_enable", enable_alu, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_dataA", dataA, 0);
        chk("rst_dataB", dataB, 0);
        chk("rst_imm", data_imm, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_timeout", out_timeout, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Reset while waiting on a full-mask op
        in_valid = 1'b1; in_opcode = 4'b0001; in_mask = '1;
        in_dataA = rnd_vec(); in_dataB = rnd_vec();
        tick();
        in_valid = 1'b0;
        tick();
        chk("midwait_enable", enable_alu, {AN{1'b1}});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_enable", enable_alu, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            ex_valid = 1'b1;
            ex_data  = rnd_vec();
            chk("midrst_no_result", out_valid, 0);
            tick();
        end
        ex_valid = 1'b0;

        rd = '0;
        rd[N-1:0] = 32'h0001_8000;
        run_op(4'b0001, 24'h000003, 3, 0, rd, 1'b0);
        run_op(4'b0100, AN'($urandom), 1, 5, rnd_vec(), 1'b1);
        run_op(4'b0010, '0, 2, 1, rnd_vec(), 1'b0);
        run_op(4'b0011, 24'h0F0F0F, 1000, 0, rnd_vec(), 1'b1);
        run_op(4'b0101, 24'h800001, TO, 0, rnd_vec(), 1'b1);
        run_op(4'b0100, '0, 1, 0, rnd_vec(), 1'b0);

        for (int n = 0; n < 40; n++) begin
            m = ($urandom_range(0, 3) == 0) ? '0 : AN'($urandom);
            k = ($urandom_range(0, 15) == 0) ? 400 : $urandom_range(1, 8);
            run_op(4'($urandom), m, k, $urandom_range(0, 3),
                   rnd_vec(), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
